spi_slave_buffer: RTL
=====================

# spi_slave_buffer

Byte-buffering stage between the SPI slave core's single-byte RX/TX holding registers and the host/register side. It drains received bytes into an RX FIFO and refills the slave's transmit register from a TX FIFO via the slave's read/write strobes. Up to DEPTH bytes in each direction can be queued without host intervention, so back-to-back SPI bytes no longer overrun the slave.

## Interface
- DEPTH, 8, FIFO depth per direction; power of two, 2..256
- AW, log2(DEPTH), pointer width

- sysclk  in  1  system clock, all logic rising-edge
- nreset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of both FIFOs, flags and the FSMs
- slave_rx_data  in  8  slave received byte
- slave_rx_ready  in  1  slave has an unread byte
- slave_rx_re  out  1  one-cycle read strobe to slave
- slave_rx_error  in  1  slave overrun flag
- slave_clear_error  out  1  registered copy of flush
- slave_tx_data  out  8  byte presented to slave transmit register
- slave_tx_we  out  1  one-cycle write strobe to slave
- slave_tx_empty  in  1  slave transmit register consumed
- host_tx_data  in  8  byte to queue
- host_tx_wr  in  1  push strobe
- host_tx_full  out  1  TX FIFO full
- host_tx_level  out  AW+1  TX occupancy
- host_rx_data  out  8  head of RX FIFO (first-word fall-through)
- host_rx_rd  in  1  pop strobe
- host_rx_empty  out  1  RX FIFO empty
- host_rx_level  out  AW+1  RX occupancy
- host_tx_ovf  out  1  sticky: push while full
- host_rx_err  out  1  sticky: slave_rx_error seen high

## Operation
- RX FSM, states RX_IDLE, RX_ACK. RX_IDLE: if slave_rx_ready=1 and RX not full → push slave_rx_data, assert slave_rx_re, go RX_ACK. RX_ACK: deassert slave_rx_re, return RX_IDLE unconditionally (one guard cycle while slave ready updates). If RX full, byte stays in slave; a later slave byte sets slave overrun, reflected by host_rx_err.
- TX FSM, states TX_IDLE, TX_WAIT. TX_IDLE: if slave_tx_empty=1 and TX not empty → load head into slave_tx_data, pop, assert slave_tx_we, go TX_WAIT. TX_WAIT: deassert, return TX_IDLE. TX empty → slave_tx_data holds last value.
- Host push when host_tx_full=1: dropped even if a pop occurs same cycle; sets host_tx_ovf. Host pop when empty: ignored, no flag.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur, level unchanged.
- Pointers wrap modulo DEPTH; level = count register, AW+1 bits, range 0..DEPTH.
- flush: clears pointers, levels, sticky flags, FSMs to IDLE, strobes low next edge; slave_clear_error pulses the cycle after flush. flush has priority over all other events in the same cycle. slave_tx_data not cleared.

## Timing
- Reset values: slave_rx_re=0, slave_tx_we=0, slave_tx_data=8'h00, slave_clear_error=0, host_tx_full=0, host_rx_empty=1, both levels=0, host_rx_data=8'h00 (don't-care when empty), flags=0.
- RX: slave_rx_ready sampled cycle N → slave_rx_re and updated host_rx_level/host_rx_empty visible cycle N+1; next capture earliest cycle N+2.
- TX: slave_tx_empty sampled cycle M → slave_tx_data and slave_tx_we valid cycle M+1; next load earliest cycle M+3 (slave_tx_empty updates M+2).
- Host push/pop: level/full/empty update the cycle after the strobe; host_rx_data reflects new head the cycle after pop.
- Reset mid-operation: all state returns to reset values immediately; in-flight strobes abort.

## Structure
- Shared package spi_pkg: byte width constant (8), default DEPTH, FSM state enums for RX and TX.
- One sub-module spi_sync_fifo (parameters DEPTH, AW; push, pop, din, dout FWFT, full, empty, level, flush), instantiated twice; FSMs and flags in the top.

## Test plan
- Reset, then slave_rx_ready=1 with 8'hA5 → slave_rx_re one cycle later for exactly one cycle; host_rx_empty=0, host_rx_data=8'hA5, level=1.
- Host pushes 8'h3C with slave_tx_empty=1 → slave_tx_data=8'h3C and single slave_tx_we pulse within 2 cycles; TX level returns 0.
- Feed DEPTH+1 RX bytes with no host reads → first DEPTH queued in order, last byte left in slave (no slave_rx_re); assert slave_rx_error → host_rx_err=1.
- Push DEPTH+1 host bytes with slave_tx_empty=0 → host_tx_full=1, level=DEPTH, host_tx_ovf=1; release slave_tx_empty → bytes delivered in order 1 per 3 cycles.
- Simultaneous host push and pop on both FIFOs at level 3 → levels stay 3, data order preserved across pointer wrap.
- flush at level 5 with pending slave_rx_ready → levels 0, flags 0, slave_clear_error pulse next cycle; nreset low mid-transfer → all outputs at reset values.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state types for the SPI slave byte buffer.
package spi_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock byte FIFO with first-word fall-through output and an occupancy count.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              sysclk,
  input  logic              nreset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  // A push into a full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by the
  // pointers and level, and dout is masked while empty, so stale contents never leak.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_slave_buffer.sv
// Byte buffering between the SPI slave holding registers and the host side:
// an RX FIFO drained from the slave and a TX FIFO that refills the slave.
module spi_slave_buffer
  import spi_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              sysclk,
  input  logic              nreset,
  input  logic              flush,
  input  logic [BYTE_W-1:0] slave_rx_data,
  input  logic              slave_rx_ready,
  output logic              slave_rx_re,
  input  logic              slave_rx_error,
  output logic              slave_clear_error,
  output logic [BYTE_W-1:0] slave_tx_data,
  output logic              slave_tx_we,
  input  logic              slave_tx_empty,
  input  logic [BYTE_W-1:0] host_tx_data,
  input  logic              host_tx_wr,
  output logic              host_tx_full,
  output logic [AW:0]       host_tx_level,
  output logic [BYTE_W-1:0] host_rx_data,
  input  logic              host_rx_rd,
  output logic              host_rx_empty,
  output logic [AW:0]       host_rx_level,
  output logic              host_tx_ovf,
  output logic              host_rx_err
);

  rx_state_t         rx_state, rx_state_next;
  tx_state_t         tx_state, tx_state_next;
  logic              rx_take;
  logic              tx_load;
  logic              rx_full;
  logic              tx_fifo_empty;
  logic [BYTE_W-1:0] tx_head;

  spi_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .sysclk (sysclk),
    .nreset (nreset),
    .flush  (flush),
    .push   (rx_take),
    .pop    (host_rx_rd),
    .din    (slave_rx_data),
    .dout   (host_rx_data),
    .full   (rx_full),
    .empty  (host_rx_empty),
    .level  (host_rx_level)
  );

  spi_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .sysclk (sysclk),
    .nreset (nreset),
    .flush  (flush),
    .push   (host_tx_wr),
    .pop    (tx_load),
    .din    (host_tx_data),
    .dout   (tx_head),
    .full   (host_tx_full),
    .empty  (tx_fifo_empty),
    .level  (host_tx_level)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rx_state_next = rx_state;
    rx_take       = 1'b0;
    if (flush) begin
      rx_state_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (slave_rx_ready && !rx_full) begin
          rx_take       = 1'b1;
          rx_state_next = RX_ACK;
        end
        // One guard cycle lets the slave drop slave_rx_ready after the read strobe.
        RX_ACK:  rx_state_next = RX_IDLE;
        default: rx_state_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_load       = 1'b0;
    if (flush) begin
      tx_state_next = TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE: if (slave_tx_empty && !tx_fifo_empty) begin
          tx_load       = 1'b1;
          tx_state_next = TX_WAIT;
        end
        TX_WAIT: tx_state_next = TX_IDLE;
        default: tx_state_next = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      rx_state          <= RX_IDLE;
      tx_state          <= TX_IDLE;
      slave_rx_re       <= 1'b0;
      slave_tx_we       <= 1'b0;
      slave_tx_data     <= '0;
      slave_clear_error <= 1'b0;
      host_tx_ovf       <= 1'b0;
      host_rx_err       <= 1'b0;
    end else begin
      rx_state          <= rx_state_next;
      tx_state          <= tx_state_next;
      slave_rx_re       <= rx_take;
      slave_tx_we       <= tx_load;
      slave_clear_error <= flush;
      // The transmit byte survives flush so the slave keeps shifting a stable value.
      if (tx_load) slave_tx_data <= tx_head;
      if (flush) begin
        host_tx_ovf <= 1'b0;
        host_rx_err <= 1'b0;
      end else begin
        if (host_tx_wr && host_tx_full) host_tx_ovf <= 1'b1;
        if (slave_rx_error)             host_rx_err <= 1'b1;
      end
    end
  end

endmodule
